decode_issue_stage: RTL and testbench

- Pipeline stage directly upstream of the ALU.
- Accepts a raw 32-bit RV32IM instruction word plus PC and decodes it into the ALU's 47-bit one-hot operation vector.
- Reads rs1/rs2 from the register file, with write-back bypass, and forms the immediate.
- Presents everything through a registered valid/ready stage with flush, so the ALU sees stable operands for a whole cycle.

---
 rtl/rv_decode_pkg.sv | 45 ++++
 rtl/rv_imm_gen.sv | 40 ++++
 rtl/decode_issue_stage.sv | 180 ++++++++++++++++++
 tb/tb_decode_issue_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_pkg.sv
// Shared RV32IM decode constants: opcodes, funct fields, one-hot operation
// indices used by both this decoder and the ALU, and immediate formats.
package rv_decode_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    localparam int unsigned OP_ADD = 0, OP_SUB = 1, OP_XOR = 2, OP_OR = 3, OP_AND = 4;
    localparam int unsigned OP_SLL = 5, OP_SRL = 6, OP_SRA = 7, OP_SLT = 8, OP_SLTU = 9;
    localparam int unsigned OP_ADDI = 10, OP_XORI = 11, OP_ORI = 12, OP_ANDI = 13;
    localparam int unsigned OP_SLLI = 14, OP_SRLI = 15, OP_SRAI = 16, OP_SLTI = 17, OP_SLTIU = 18;
    localparam int unsigned OP_LB = 19, OP_LH = 20, OP_LW = 21, OP_LBU = 22, OP_LHU = 23;
    localparam int unsigned OP_SB = 24, OP_SH = 25, OP_SW = 26;
    localparam int unsigned OP_BEQ = 27, OP_BNE = 28, OP_BLT = 29, OP_BGE = 30;
    localparam int unsigned OP_BLTU = 31, OP_BGEU = 32;
    localparam int unsigned OP_JAL = 33, OP_JALR = 34, OP_LUI = 35, OP_AUIPC = 36;
    localparam int unsigned OP_MUL = 39, OP_MULH = 40, OP_MULHSU = 41, OP_MULHU = 42;
    localparam int unsigned OP_DIV = 43, OP_DIVU = 44, OP_REM = 45, OP_REMU = 46;

    typedef enum logic [2:0] {
        FMT_NONE,
        FMT_R,
        FMT_I,
        FMT_SH,
        FMT_S,
        FMT_B,
        FMT_J,
        FMT_U
    } imm_fmt_t;

endpackage

// File: rtl/rv_imm_gen.sv
// Classifies the instruction format from its opcode and builds the
// sign-extended 32-bit immediate.
module rv_imm_gen
    import rv_decode_pkg::*;
(
    input  logic [31:0] instr,
    output imm_fmt_t    fmt,
    output logic [31:0] imm
);

    always_comb begin
        fmt = FMT_NONE;
        case (instr[6:0])
            OPC_OP:     fmt = FMT_R;
            OPC_OPIMM:  fmt = (instr[14:12] == F3_SLL || instr[14:12] == F3_SR) ? FMT_SH : FMT_I;
            OPC_LOAD:   fmt = FMT_I;
            OPC_JALR:   fmt = FMT_I;
            OPC_STORE:  fmt = FMT_S;
            OPC_BRANCH: fmt = FMT_B;
            OPC_JAL:    fmt = FMT_J;
            OPC_LUI:    fmt = FMT_U;
            OPC_AUIPC:  fmt = FMT_U;
            default:    fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        imm = '0;
        case (fmt)
            FMT_I:   imm = {{20{instr[31]}}, instr[31:20]};
            FMT_SH:  imm = {27'h0, instr[24:20]};
            FMT_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            FMT_U:   imm = {instr[31:12], 12'h0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_issue_stage.sv
// RV32IM decode/issue stage: one-hot operation decode, operand read with
// write-back bypass, immediate formation, and a registered valid/ready output.
module decode_issue_stage
    import rv_decode_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     OP_W     = 47,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    input  logic            flush,
    output logic [4:0]      rf_raddr1,
    output logic [4:0]      rf_raddr2,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic            wb_en,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [OP_W-1:0] op_o,
    output logic [XLEN-1:0] rs1_o,
    output logic [XLEN-1:0] rs2_o,
    output logic [XLEN-1:0] imm_o,
    output logic [XLEN-1:0] pc_o,
    output logic [4:0]      rd_o,
    output logic            illegal_o
);

    imm_fmt_t        fmt;
    logic [31:0]     imm_d;
    logic [OP_W-1:0] op_d;
    logic [XLEN-1:0] rs1_d, rs2_d;
    logic [4:0]      rd_d;
    logic [XLEN-1:0] pc_q;
    logic            accept;

    wire [2:0] f3 = in_instr[14:12];
    wire [6:0] f7 = in_instr[31:25];

    rv_imm_gen u_imm (
        .instr (in_instr),
        .fmt   (fmt),
        .imm   (imm_d)
    );

    assign rf_raddr1 = in_instr[19:15];
    assign rf_raddr2 = in_instr[24:20];
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign pc_o      = out_valid ? pc_q : RESET_PC;

    function automatic logic [XLEN-1:0] read_reg(input logic [4:0] addr, input logic [XLEN-1:0] rf,
                                                 input logic en, input logic [4:0] wa,
                                                 input logic [XLEN-1:0] wd);
        if (addr == 5'd0)            return '0;
        else if (en && wa == addr)   return wd;
        else                         return rf;
    endfunction

    // An all-zero op vector is what marks an instruction as illegal.
    always_comb begin
        op_d = '0;
        case (in_instr[6:0])
            OPC_OP: begin
                case (f7)
                    F7_BASE: case (f3)
                        3'b000: op_d[OP_ADD]  = 1'b1;
                        3'b001: op_d[OP_SLL]  = 1'b1;
                        3'b010: op_d[OP_SLT]  = 1'b1;
                        3'b011: op_d[OP_SLTU] = 1'b1;
                        3'b100: op_d[OP_XOR]  = 1'b1;
                        3'b101: op_d[OP_SRL]  = 1'b1;
                        3'b110: op_d[OP_OR]   = 1'b1;
                        default: op_d[OP_AND] = 1'b1;
                    endcase
                    F7_ALT: case (f3)
                        3'b000:  op_d[OP_SUB] = 1'b1;
                        3'b101:  op_d[OP_SRA] = 1'b1;
                        default: ;
                    endcase
                    F7_MULDIV: case (f3)
                        3'b000: op_d[OP_MUL]    = 1'b1;
                        3'b001: op_d[OP_MULH]   = 1'b1;
                        3'b010: op_d[OP_MULHSU] = 1'b1;
                        3'b011: op_d[OP_MULHU]  = 1'b1;
                        3'b100: op_d[OP_DIV]    = 1'b1;
                        3'b101: op_d[OP_DIVU]   = 1'b1;
                        3'b110: op_d[OP_REM]    = 1'b1;
                        default: op_d[OP_REMU]  = 1'b1;
                    endcase
                    default: ;
                endcase
            end
            OPC_OPIMM: case (f3)
                3'b000: op_d[OP_ADDI]  = 1'b1;
                3'b010: op_d[OP_SLTI]  = 1'b1;
                3'b011: op_d[OP_SLTIU] = 1'b1;
                3'b100: op_d[OP_XORI]  = 1'b1;
                3'b110: op_d[OP_ORI]   = 1'b1;
                3'b111: op_d[OP_ANDI]  = 1'b1;
                3'b001: op_d[OP_SLLI]  = (f7 == F7_BASE);
                default: begin
                    op_d[OP_SRLI] = (f7 == F7_BASE);
                    op_d[OP_SRAI] = (f7 == F7_ALT);
                end
            endcase
            OPC_LOAD: case (f3)
                3'b000:  op_d[OP_LB]  = 1'b1;
                3'b001:  op_d[OP_LH]  = 1'b1;
                3'b010:  op_d[OP_LW]  = 1'b1;
                3'b100:  op_d[OP_LBU] = 1'b1;
                3'b101:  op_d[OP_LHU] = 1'b1;
                default: ;
            endcase
            OPC_STORE: case (f3)
                3'b000:  op_d[OP_SB] = 1'b1;
                3'b001:  op_d[OP_SH] = 1'b1;
                3'b010:  op_d[OP_SW] = 1'b1;
                default: ;
            endcase
            OPC_BRANCH: case (f3)
                3'b000:  op_d[OP_BEQ]  = 1'b1;
                3'b001:  op_d[OP_BNE]  = 1'b1;
                3'b100:  op_d[OP_BLT]  = 1'b1;
                3'b101:  op_d[OP_BGE]  = 1'b1;
                3'b110:  op_d[OP_BLTU] = 1'b1;
                3'b111:  op_d[OP_BGEU] = 1'b1;
                default: ;
            endcase
            OPC_JAL:   op_d[OP_JAL]   = 1'b1;
            OPC_JALR:  op_d[OP_JALR]  = (f3 == 3'b000);
            OPC_LUI:   op_d[OP_LUI]   = 1'b1;
            OPC_AUIPC: op_d[OP_AUIPC] = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        rs1_d = '0;
        rs2_d = '0;
        if (fmt inside {FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B})
            rs1_d = read_reg(rf_raddr1, rf_rdata1, wb_en, wb_rd, wb_data);
        if (fmt inside {FMT_R, FMT_S, FMT_B})
            rs2_d = read_reg(rf_raddr2, rf_rdata2, wb_en, wb_rd, wb_data);
        rd_d = (fmt == FMT_S || fmt == FMT_B) ? 5'd0 : in_instr[11:7];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            op_o      <= '0;
            rs1_o     <= '0;
            rs2_o     <= '0;
            imm_o     <= '0;
            rd_o      <= '0;
            illegal_o <= 1'b0;
            pc_q      <= RESET_PC;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            op_o      <= op_d;
            rs1_o     <= rs1_d;
            rs2_o     <= rs2_d;
            imm_o     <= imm_d;
            rd_o      <= rd_d;
            illegal_o <= (op_d == '0);
            pc_q      <= in_pc;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_issue_stage.sv
// Bench for decode_issue_stage: directed scenarios plus randomized traffic
// checked against a mask/match instruction table model.
module tb_decode_issue_stage;

    localparam logic [31:0] RST_PC = 32'h0000_8000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0, wb_en = 1'b0;
    logic        in_ready, out_valid, illegal_o;
    logic [31:0] in_instr = '0, in_pc = '0, rf_rdata1 = '0, rf_rdata2 = '0, wb_data = '0;
    logic [4:0]  wb_rd = '0, rf_raddr1, rf_raddr2, rd_o;
    logic [46:0] op_o;
    logic [31:0] rs1_o, rs2_o, imm_o, pc_o;

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    decode_issue_stage #(.XLEN(32), .OP_W(47), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
        .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .op_o(op_o), .rs1_o(rs1_o), .rs2_o(rs2_o), .imm_o(imm_o),
        .pc_o(pc_o), .rd_o(rd_o), .illegal_o(illegal_o)
    );

    typedef struct packed {
        logic [31:0] mask;
        logic [31:0] match;
        logic [7:0]  idx;
    } pat_t;

    pat_t pats [0:44] = '{
        '{32'hFE00707F, 32'h00000033, 8'd0},  '{32'hFE00707F, 32'h40000033, 8'd1},
        '{32'hFE00707F, 32'h00004033, 8'd2},  '{32'hFE00707F, 32'h00006033, 8'd3},
        '{32'hFE00707F, 32'h00007033, 8'd4},  '{32'hFE00707F, 32'h00001033, 8'd5},
        '{32'hFE00707F, 32'h00005033, 8'd6},  '{32'hFE00707F, 32'h40005033, 8'd7},
        '{32'hFE00707F, 32'h00002033, 8'd8},  '{32'hFE00707F, 32'h00003033, 8'd9},
        '{32'h0000707F, 32'h00000013, 8'd10}, '{32'h0000707F, 32'h00004013, 8'd11},
        '{32'h0000707F, 32'h00006013, 8'd12}, '{32'h0000707F, 32'h00007013, 8'd13},
        '{32'hFE00707F, 32'h00001013, 8'd14}, '{32'hFE00707F, 32'h00005013, 8'd15},
        '{32'hFE00707F, 32'h40005013, 8'd16}, '{32'h0000707F, 32'h00002013, 8'd17},
        '{32'h0000707F, 32'h00003013, 8'd18}, '{32'h0000707F, 32'h00000003, 8'd19},
        '{32'h0000707F, 32'h00001003, 8'd20}, '{32'h0000707F, 32'h00002003, 8'd21},
        '{32'h0000707F, 32'h00004003, 8'd22}, '{32'h0000707F, 32'h00005003, 8'd23},
        '{32'h0000707F, 32'h00000023, 8'd24}, '{32'h0000707F, 32'h00001023, 8'd25},
        '{32'h0000707F, 32'h00002023, 8'd26}, '{32'h0000707F, 32'h00000063, 8'd27},
        '{32'h0000707F, 32'h00001063, 8'd28}, '{32'h0000707F, 32'h00004063, 8'd29},
        '{32'h0000707F, 32'h00005063, 8'd30}, '{32'h0000707F, 32'h00006063, 8'd31},
        '{32'h0000707F, 32'h00007063, 8'd32}, '{32'h0000007F, 32'h0000006F, 8'd33},
        '{32'h0000707F, 32'h00000067, 8'd34}, '{32'h0000007F, 32'h00000037, 8'd35},
        '{32'h0000007F, 32'h00000017, 8'd36}, '{32'hFE00707F, 32'h02000033, 8'd39},
        '{32'hFE00707F, 32'h02001033, 8'd40}, '{32'hFE00707F, 32'h02002033, 8'd41},
        '{32'hFE00707F, 32'h02003033, 8'd42}, '{32'hFE00707F, 32'h02004033, 8'd43},
        '{32'hFE00707F, 32'h02005033, 8'd44}, '{32'hFE00707F, 32'h02006033, 8'd45},
        '{32'hFE00707F, 32'h02007033, 8'd46}
    };

    typedef struct packed {
        logic [46:0] op;
        logic [31:0] rs1, rs2, imm, pc;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    function automatic int ref_idx(input logic [31:0] i);
        for (int p = 0; p < 45; p++)
            if ((i & pats[p].mask) == pats[p].match) return int'(pats[p].idx);
        return -1;
    endfunction

    function automatic logic [31:0] ref_reg(input logic [4:0] a, input logic [31:0] rf,
                                            input logic en, input logic [4:0] wa,
                                            input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (en && wa == a) return wd;
        return rf;
    endfunction

    function automatic exp_t ref_model(input logic [31:0] i, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2,
                                       input logic en, input logic [4:0] wa, input logic [31:0] wd);
        exp_t e;
        int   k;
        logic is_r, is_sh, is_i, is_s, is_b, is_j, is_u;
        k = ref_idx(i);
        e = '0;
        e.pc  = pc;
        e.ill = (k < 0);
        if (k < 0) return e;
        e.op  = 47'h1 << k;
        is_r  = (k <= 9) || (k >= 39);
        is_sh = (k >= 14 && k <= 16);
        is_i  = ((k >= 10 && k <= 23) && !is_sh) || k == 34;
        is_s  = (k >= 24 && k <= 26);
        is_b  = (k >= 27 && k <= 32);
        is_j  = (k == 33);
        is_u  = (k == 35 || k == 36);
        if (is_i)  e.imm = {{20{i[31]}}, i[31:20]};
        if (is_sh) e.imm = {27'h0, i[24:20]};
        if (is_s)  e.imm = {{20{i[31]}}, i[31:25], i[11:7]};
        if (is_b)  e.imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
        if (is_j)  e.imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
        if (is_u)  e.imm = {i[31:12], 12'h0};
        if (!(is_u || is_j))         e.rs1 = ref_reg(i[19:15], r1, en, wa, wd);
        if (is_r || is_s || is_b)    e.rs2 = ref_reg(i[24:20], r2, en, wa, wd);
        e.rd = (is_s || is_b) ? 5'd0 : i[11:7];
        return e;
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic ordy, input logic [31:0] d1, input logic [31:0] d2);
        in_valid  = v;
        in_instr  = ins;
        in_pc     = pc;
        out_ready = ordy;
        rf_rdata1 = d1;
        rf_rdata2 = d2;
        flush     = 1'b0;
        wb_en     = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        nchk++; if (pc_o !== RST_PC) begin nerr++; $display("FAIL reset_pc got=%h exp=%h", pc_o, RST_PC); end
        nchk++; if ({op_o, rs1_o, rs2_o, imm_o, rd_o, illegal_o} !== '0) begin
            nerr++; $display("FAIL reset_regs op=%h rs1=%h rs2=%h imm=%h rd=%0d ill=%b exp all 0",
                             op_o, rs1_o, rs2_o, imm_o, rd_o, illegal_o);
        end
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        do_reset();
    endtask

    task automatic test_add();
        @(negedge clk);
        drive(1'b1, 32'h002081B3, 32'h40, 1'b1, 32'd5, 32'd7);
        #1;
        nchk++; if (rf_raddr1 !== 5'd1 || rf_raddr2 !== 5'd2) begin
            nerr++; $display("FAIL add_raddr got=%0d,%0d exp=1,2", rf_raddr1, rf_raddr2);
        end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        nchk++; if (out_valid !== 1'b1 || op_o !== 47'h1) begin
            nerr++; $display("FAIL add_op valid=%b op=%h exp valid=1 op=1", out_valid, op_o);
        end
        nchk++; if (rs1_o !== 32'd5 || rs2_o !== 32'd7 || rd_o !== 5'd3 || imm_o !== 32'h0 || pc_o !== 32'h40) begin
            nerr++; $display("FAIL add_fields rs1=%h rs2=%h rd=%0d imm=%h pc=%h exp 5,7,3,0,40",
                             rs1_o, rs2_o, rd_o, imm_o, pc_o);
        end
    endtask

    task automatic test_addi();
        @(negedge clk);
        drive(1'b1, 32'hFFF00293, 32'h44, 1'b1, 32'h1234, 32'd99);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        nchk++; if (op_o !== 47'h400 || imm_o !== 32'hFFFFFFFF) begin
            nerr++; $display("FAIL addi_op op=%h imm=%h exp 400,ffffffff", op_o, imm_o);
        end
        nchk++; if (rs1_o !== 32'h0 || rs2_o !== 32'h0 || rd_o !== 5'd5) begin
            nerr++; $display("FAIL addi_fields rs1=%h rs2=%h rd=%0d exp 0,0,5", rs1_o, rs2_o, rd_o);
        end
    endtask

    task automatic test_mul_bypass();
        @(negedge clk);
        drive(1'b1, 32'h023100B3, 32'h48, 1'b1, 32'h1111, 32'h2222);
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'hABCD;
        @(negedge clk);
        in_valid = 1'b0; wb_en = 1'b0;
        #1;
        nchk++; if (op_o !== 47'h8000000000 || rd_o !== 5'd1) begin
            nerr++; $display("FAIL mul_op op=%h rd=%0d exp 8000000000,1", op_o, rd_o);
        end
        nchk++; if (rs1_o !== 32'hABCD || rs2_o !== 32'h2222) begin
            nerr++; $display("FAIL mul_bypass rs1=%h rs2=%h exp abcd,2222", rs1_o, rs2_o);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        drive(1'b1, 32'h002081B3, 32'h100, 1'b0, 32'd5, 32'd7);
        @(negedge clk);
        drive(1'b1, 32'hFFF00293, 32'h104, 1'b0, 32'h0, 32'h0);
        for (int c = 0; c < 3; c++) begin
            #1;
            nchk++; if (in_ready !== 1'b0) begin nerr++; $display("FAIL stall_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
            nchk++; if (out_valid !== 1'b1 || op_o !== 47'h1 || pc_o !== 32'h100 || rs1_o !== 32'd5 || rs2_o !== 32'd7) begin
                nerr++; $display("FAIL stall_hold cyc=%0d valid=%b op=%h pc=%h rs1=%h rs2=%h exp 1,1,100,5,7",
                                 c, out_valid, op_o, pc_o, rs1_o, rs2_o);
            end
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        nchk++; if (in_ready !== 1'b1) begin nerr++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        nchk++; if (out_valid !== 1'b1 || op_o !== 47'h400 || pc_o !== 32'h104) begin
            nerr++; $display("FAIL b2b_next valid=%b op=%h pc=%h exp 1,400,104", out_valid, op_o, pc_o);
        end
        @(negedge clk);
        #1;
        nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL drain_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_illegal();
        @(negedge clk);
        drive(1'b1, 32'hFFFFFFFF, 32'h200, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        nchk++; if (out_valid !== 1'b1 || illegal_o !== 1'b1 || op_o !== 47'h0) begin
            nerr++; $display("FAIL illegal valid=%b ill=%b op=%h exp 1,1,0", out_valid, illegal_o, op_o);
        end
    endtask

    task automatic test_flush();
        @(negedge clk);
        drive(1'b1, 32'h002081B3, 32'h300, 1'b0, 32'd5, 32'd7);
        @(negedge clk);
        drive(1'b1, 32'hFFF00293, 32'h304, 1'b1, 32'h0, 32'h0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        nchk++; if (out_valid !== 1'b0 || pc_o !== RST_PC) begin
            nerr++; $display("FAIL flush_valid valid=%b pc=%h exp 0,%h", out_valid, pc_o, RST_PC);
        end
        @(negedge clk);
        #1;
        nchk++; if (out_valid !== 1'b0) begin nerr++; $display("FAIL flush_no_accept got=%b exp=0", out_valid); end
    endtask

    task automatic test_reset_mid_stall();
        @(negedge clk);
        drive(1'b1, 32'h002081B3, 32'h400, 1'b0, 32'd5, 32'd7);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        nchk++; if (out_valid !== 1'b0 || pc_o !== RST_PC || op_o !== 47'h0 || rs1_o !== 32'h0) begin
            nerr++; $display("FAIL reset_mid valid=%b pc=%h op=%h rs1=%h exp 0,%h,0,0", out_valid, pc_o, op_o, rs1_o, RST_PC);
        end
        do_reset();
    endtask

    task automatic test_random();
        exp_t        m_exp;
        logic        m_valid;
        logic [31:0] ins;
        int          sel;
        m_valid = 1'b0;
        m_exp   = '0;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            sel = int'($urandom_range(0, 99));
            if (sel < 80) begin
                sel = int'($urandom_range(0, 44));
                ins = ($urandom & ~pats[sel].mask) | pats[sel].match;
            end else if (sel < 90) begin
                ins = {$urandom} & 32'hFFFF_FFFC;
            end else begin
                ins = {7'b0000010, 25'($urandom) & 25'h1FFFF80, 7'b0110011};
            end
            in_instr  = ins;
            in_pc     = {$urandom} & 32'hFFFF_FFFC;
            in_valid  = ($urandom_range(0, 9) < 7);
            out_ready = ($urandom_range(0, 9) < 7);
            flush     = ($urandom_range(0, 19) == 0);
            rf_rdata1 = $urandom;
            rf_rdata2 = $urandom;
            wb_en     = $urandom_range(0, 1) == 1;
            wb_data   = $urandom;
            case ($urandom_range(0, 2))
                0:       wb_rd = ins[19:15];
                1:       wb_rd = ins[24:20];
                default: wb_rd = 5'($urandom);
            endcase
            #1;
            nchk++; if (out_valid !== m_valid) begin nerr++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", c, out_valid, m_valid); end
            nchk++; if (in_ready !== (!m_valid || out_ready)) begin
                nerr++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", c, in_ready, !m_valid || out_ready);
            end
            nchk++; if (rf_raddr1 !== ins[19:15] || rf_raddr2 !== ins[24:20]) begin
                nerr++; $display("FAIL rnd_raddr cyc=%0d got=%0d,%0d exp=%0d,%0d", c, rf_raddr1, rf_raddr2, ins[19:15], ins[24:20]);
            end
            if (m_valid) begin
                nchk++; if (op_o !== m_exp.op || illegal_o !== m_exp.ill || pc_o !== m_exp.pc) begin
                    nerr++; $display("FAIL rnd_op cyc=%0d op=%h ill=%b pc=%h exp op=%h ill=%b pc=%h",
                                     c, op_o, illegal_o, pc_o, m_exp.op, m_exp.ill, m_exp.pc);
                end
                if (!m_exp.ill) begin
                    nchk++; if (rs1_o !== m_exp.rs1 || rs2_o !== m_exp.rs2 || imm_o !== m_exp.imm || rd_o !== m_exp.rd) begin
                        nerr++; $display("FAIL rnd_fields cyc=%0d rs1=%h rs2=%h imm=%h rd=%0d exp rs1=%h rs2=%h imm=%h rd=%0d",
                                         c, rs1_o, rs2_o, imm_o, rd_o, m_exp.rs1, m_exp.rs2, m_exp.imm, m_exp.rd);
                    end
                end
            end
            if (flush) begin
                m_valid = 1'b0;
            end else if (in_valid && (!m_valid || out_ready)) begin
                m_exp   = ref_model(ins, in_pc, rf_rdata1, rf_rdata2, wb_en, wb_rd, wb_data);
                m_valid = 1'b1;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
        end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_add();
        test_addi();
        test_mul_bypass();
        test_back_to_back();
        test_illegal();
        test_flush();
        test_reset_mid_stall();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
